// File: rtl/gray_sobel_frame_seq.sv
// Frame-level sequencer for the grayscale/Sobel core: latches per-frame config,
// streams W*H pixels into the core, flushes until EXP outputs are collected,
// then pulses frame_done_o.
// Optional build macro FRAME_SEQ_WATCHDOG_EN adds a FLUSH watchdog
// (parameter WDOG_CYCLES, output wdog_err_o).
module gray_sobel_frame_seq #(
    parameter int unsigned MAX_PIXEL_BITS = 24,
    parameter int unsigned COORD_BITS     = 10,
    parameter int unsigned PIPE_LAT       = 1,
    parameter int unsigned CNT_BITS       = 2 * COORD_BITS
`ifdef FRAME_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES    = 4096
`endif
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [COORD_BITS-1:0]     cfg_width_i,
    input  logic [COORD_BITS-1:0]     cfg_height_i,
    input  logic                      frame_start_i,
    input  logic                      in_valid_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    output logic                      in_ready_o,
    output logic [1:0]                core_select_o,
    output logic                      core_start_o,
    output logic [MAX_PIXEL_BITS-1:0] core_pixel_o,
    input  logic [MAX_PIXEL_BITS-1:0] core_pixel_i,
    input  logic                      core_px_ready_i,
    output logic                      out_valid_o,
    output logic [MAX_PIXEL_BITS-1:0] out_pixel_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      underrun_o,
    output logic                      cfg_err_o
`ifdef FRAME_SEQ_WATCHDOG_EN
    ,
    output logic                      wdog_err_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [CNT_BITS-1:0]       total_q, total_d;
    logic [CNT_BITS-1:0]       exp_q, exp_d;
    logic [CNT_BITS-1:0]       in_cnt_q, in_cnt_d;
    logic [CNT_BITS-1:0]       out_cnt_q, out_cnt_d;
    logic [PIPE_LAT-1:0]       pipe_q, pipe_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [MAX_PIXEL_BITS-1:0] out_pixel_q, out_pixel_d;
    logic                      underrun_q, underrun_d;
    logic                      cfg_err_q, cfg_err_d;

    logic                      cfg_sobel, cfg_bad, sobel_q, in_run, in_collect, accept;
    logic [CNT_BITS-1:0]       w_ext, h_ext;

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam int unsigned WDOG_BITS = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_BITS-1:0]      wdog_q, wdog_d;
    logic                      wdog_err_q, wdog_err_d;
    assign wdog_err_o = wdog_err_q;
`endif

    // Config qualification and datapath helpers
    assign cfg_sobel  = (cfg_mode_i == 2'b01) || (cfg_mode_i == 2'b10);
    assign cfg_bad    = (cfg_width_i == '0) || (cfg_height_i == '0) ||
                        (cfg_sobel && ((cfg_width_i < COORD_BITS'(3)) ||
                                       (cfg_height_i < COORD_BITS'(3))));
    assign w_ext      = CNT_BITS'(cfg_width_i);
    assign h_ext      = CNT_BITS'(cfg_height_i);
    assign sobel_q    = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign in_run     = (state_q == RUN);
    assign in_collect = (state_q == RUN) || (state_q == FLUSH);
    assign accept     = in_collect && (out_cnt_q != exp_q) &&
                        (sobel_q ? core_px_ready_i : pipe_q[PIPE_LAT-1]);

    // State-decoded control outputs and the pixel path into the core
    assign in_ready_o    = in_run;
    assign core_start_o  = in_collect;
    assign core_select_o = (state_q != IDLE) ? mode_q : 2'b00;
    assign core_pixel_o  = (in_run && in_valid_i) ? in_pixel_i : '0;
    assign busy_o        = (state_q != IDLE);
    assign frame_done_o  = (state_q == DONE);
    assign out_valid_o   = out_valid_q;
    assign out_pixel_o   = out_pixel_q;
    assign out_last_o    = out_last_q;
    assign underrun_o    = underrun_q;
    assign cfg_err_o     = cfg_err_q;

    // Next-state, counters and output collection
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        total_d     = total_q;
        exp_d       = exp_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        pipe_d      = (state_q == IDLE) ? '0 : PIPE_LAT'({pipe_q, in_run});
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_pixel_d = out_pixel_q;
        underrun_d  = underrun_q;
        cfg_err_d   = 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
        wdog_d      = '0;
        wdog_err_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    underrun_d = 1'b0;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        mode_d    = cfg_mode_i;
                        total_d   = w_ext * h_ext;
                        exp_d     = cfg_sobel ? (w_ext - CNT_BITS'(2)) * (h_ext - CNT_BITS'(2))
                                              : w_ext * h_ext;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                in_cnt_d = in_cnt_q + CNT_BITS'(1);
                if (!in_valid_i) underrun_d = 1'b1;
                if (in_cnt_q == total_q - CNT_BITS'(1)) state_d = FLUSH;
            end
            FLUSH: begin
                if (out_cnt_q == exp_q) begin
                    state_d = DONE;
                end
`ifdef FRAME_SEQ_WATCHDOG_EN
                else if (!accept) begin
                    wdog_d = wdog_q + WDOG_BITS'(1);
                    if (wdog_q == WDOG_BITS'(WDOG_CYCLES - 1)) begin
                        state_d    = IDLE;
                        wdog_err_d = 1'b1;
                    end
                end
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            out_valid_d = 1'b1;
            out_pixel_d = core_pixel_i;
            out_cnt_d   = out_cnt_q + CNT_BITS'(1);
            out_last_d  = (out_cnt_q + CNT_BITS'(1) == exp_q);
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            total_q     <= '0;
            exp_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pipe_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pixel_q <= '0;
            underrun_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
            wdog_q      <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            total_q     <= total_d;
            exp_q       <= exp_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pipe_q      <= pipe_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_pixel_q <= out_pixel_d;
            underrun_q  <= underrun_d;
            cfg_err_q   <= cfg_err_d;
`ifdef FRAME_SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_gray_sobel_frame_seq.sv
// Directed bench for gray_sobel_frame_seq; a 1-cycle pass-through core model
// feeds core_pixel_i, Sobel strobes are driven directly.
module tb_gray_sobel_frame_seq;

    logic        clk;
    logic        nreset;
    logic [1:0]  cfg_mode;
    logic [9:0]  cfg_width, cfg_height;
    logic        frame_start, in_valid, in_ready;
    logic [23:0] in_pixel, core_pixel_o, core_pixel_i, out_pixel;
    logic [1:0]  core_select;
    logic        core_start, core_px_ready, out_valid, out_last;
    logic        busy, frame_done, underrun, cfg_err;
`ifdef FRAME_SEQ_WATCHDOG_EN
    logic        wdog_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FRAME_SEQ_WATCHDOG_EN
    gray_sobel_frame_seq #(.MAX_PIXEL_BITS(24), .COORD_BITS(10), .PIPE_LAT(1), .WDOG_CYCLES(16)) dut (
        .clk_i(clk), .nreset_i(nreset),
        .cfg_mode_i(cfg_mode), .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
        .frame_start_i(frame_start), .in_valid_i(in_valid), .in_pixel_i(in_pixel),
        .in_ready_o(in_ready), .core_select_o(core_select), .core_start_o(core_start),
        .core_pixel_o(core_pixel_o), .core_pixel_i(core_pixel_i),
        .core_px_ready_i(core_px_ready), .out_valid_o(out_valid), .out_pixel_o(out_pixel),
        .out_last_o(out_last), .busy_o(busy), .frame_done_o(frame_done),
        .underrun_o(underrun), .cfg_err_o(cfg_err), .wdog_err_o(wdog_err)
    );
`else
    gray_sobel_frame_seq #(.MAX_PIXEL_BITS(24), .COORD_BITS(10), .PIPE_LAT(1)) dut (
        .clk_i(clk), .nreset_i(nreset),
        .cfg_mode_i(cfg_mode), .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
        .frame_start_i(frame_start), .in_valid_i(in_valid), .in_pixel_i(in_pixel),
        .in_ready_o(in_ready), .core_select_o(core_select), .core_start_o(core_start),
        .core_pixel_o(core_pixel_o), .core_pixel_i(core_pixel_i),
        .core_px_ready_i(core_px_ready), .out_valid_o(out_valid), .out_pixel_o(out_pixel),
        .out_last_o(out_last), .busy_o(busy), .frame_done_o(frame_done),
        .underrun_o(underrun), .cfg_err_o(cfg_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: one-cycle pass-through of the pixel fed to the core
    always_ff @(posedge clk) core_pixel_i <= core_pixel_o;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [1:0] m, input int w, input int h);
        cfg_mode    = m;
        cfg_width   = 10'(w);
        cfg_height  = 10'(h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Full gray/bypass frame; gap >= 0 drops in_valid for that pixel index
    task automatic run_pass(input logic [1:0] m, input int w, input int h, input int gap);
        int n;
        logic [31:0] e;
        n = w * h;
        start_frame(m, w, h);
        for (int p = 0; p <= n + 2; p++) begin
            in_valid = (p < n) && (p != gap);
            in_pixel = (p < n) ? 24'(p + 1) : 24'hAA;
            #1;
            chk("in_ready", 32'(in_ready), 32'(p < n));
            chk("core_start", 32'(core_start), 32'(p <= n + 1));
            chk("core_select", 32'(core_select), 32'(m));
            chk("core_pixel", 32'(core_pixel_o), (p < n && p != gap) ? 32'(p + 1) : 32'h0);
            chk("underrun", 32'(underrun), 32'(gap >= 0 && p > gap));
            if (p >= 2 && p < n + 2) begin
                e = (p - 2 == gap) ? 32'h0 : 32'(p - 1);
                chk("out_valid", 32'(out_valid), 32'h1);
                chk("out_pixel", 32'(out_pixel), e);
                chk("out_last", 32'(out_last), 32'(p - 2 == n - 1));
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'h0);
            end
            chk("frame_done", 32'(frame_done), 32'(p == n + 2));
            chk("busy", 32'(busy), 32'h1);
            tick();
        end
        in_valid = 1'b0;
        chk("busy_after", 32'(busy), 32'h0);
        chk("done_after", 32'(frame_done), 32'h0);
        chk("select_after", 32'(core_select), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_out, n_done, n_last;
        nreset = 1'b0; cfg_mode = 2'b00; cfg_width = '0; cfg_height = '0;
        frame_start = 1'b0; in_valid = 1'b0; in_pixel = '0; core_px_ready = 1'b0;
        tick(); tick();
        nreset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_start", 32'(core_start), 32'h0);
        chk("rst_select", 32'(core_select), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_flags", 32'({underrun, cfg_err}), 32'h0);
        tick();

        // Bypass 4x2, gapless
        run_pass(2'b11, 4, 2, -1);

        // Sobel-only 5x4: EXP=6, 7 strobes, mid-frame request ignored
        start_frame(2'b01, 5, 4);
        for (int p = 0; p < 20; p++) begin
            in_valid = 1'b1;
            in_pixel = 24'(p + 100);
            frame_start = (p == 5);
            if (p == 5) begin cfg_width = '0; cfg_mode = 2'b10; end
            #1;
            if (p == 6) begin
                chk("busy_start_ignored", 32'(cfg_err), 32'h0);
                chk("busy_select_held", 32'(core_select), 32'h1);
            end
            tick();
        end
        frame_start = 1'b0; in_valid = 1'b0;
        n_out = 0; n_done = 0; n_last = 0;
        for (int c = 0; c < 12; c++) begin
            core_px_ready = (c < 7);
            #1;
            if (out_valid) n_out++;
            if (out_last) n_last++;
            if (frame_done) n_done++;
            tick();
        end
        core_px_ready = 1'b0;
        chk("sobel_out_count", 32'(n_out), 32'd6);
        chk("sobel_last_count", 32'(n_last), 32'd1);
        chk("sobel_done_count", 32'(n_done), 32'd1);
        chk("sobel_busy_end", 32'(busy), 32'h0);

        // Gray 3x3 with a bubble on the 4th pixel
        run_pass(2'b00, 3, 3, 3);
        chk("underrun_sticky", 32'(underrun), 32'h1);

        // Rejected requests: gray+sobel 2x8, bypass 0x5
        start_frame(2'b10, 2, 8);
        chk("rej_cfg_err", 32'(cfg_err), 32'h1);
        chk("rej_busy", 32'(busy), 32'h0);
        chk("rej_underrun_clr", 32'(underrun), 32'h0);
        tick();
        chk("rej_cfg_err_pulse", 32'(cfg_err), 32'h0);
        chk("rej_busy2", 32'(busy), 32'h0);
        start_frame(2'b11, 0, 5);
        chk("rej_zero_w", 32'(cfg_err), 32'h1);
        chk("rej_zero_w_busy", 32'(busy), 32'h0);
        tick();

        // Gray+sobel 4x4 aborted by reset mid-RUN
        start_frame(2'b10, 4, 4);
        in_valid = 1'b1; in_pixel = 24'h55; core_px_ready = 1'b1;
        tick();
        core_px_ready = 1'b0;
        #1;
        chk("abort_pre_valid", 32'(out_valid), 32'h1);
        chk("abort_pre_select", 32'(core_select), 32'h2);
        nreset = 1'b0;
        tick();
        nreset = 1'b1; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_start", 32'(core_start), 32'h0);
        chk("abort_select", 32'(core_select), 32'h0);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            if (frame_done) n_done++;
            tick();
        end
        chk("abort_no_done", 32'(n_done), 32'd0);

`ifdef FRAME_SEQ_WATCHDOG_EN
        // Sobel-only 3x3 where the core never strobes
        start_frame(2'b01, 3, 3);
        in_valid = 1'b1;
        for (int p = 0; p < 9; p++) tick();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("wdog_wait", 32'({wdog_err, busy}), 32'h1);
            tick();
        end
        chk("wdog_err", 32'(wdog_err), 32'h1);
        chk("wdog_idle", 32'(busy), 32'h0);
        chk("wdog_start", 32'(core_start), 32'h0);
        chk("wdog_no_done", 32'(frame_done), 32'h0);
        tick();
        chk("wdog_pulse", 32'(wdog_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
